test_csr_mmio_mgr: RTL and testbench

CSR manager stage that drives the CSR-side modport of the test_csrs interface. It decodes host MMIO reads and writes (flattened CCI-P channel 0 MMIO requests), returns read data through a buffered response path (channel 2 MMIO response), and produces one-cycle write strobes toward the test module. It exposes a fixed AFU device feature header (DFH), the test-supplied AFU ID, and NUM_TEST_CSRS generic test CSRs.

---
 rtl/test_csr_mgr_pkg.sv | 29 ++
 rtl/test_csrs.sv | 11 +
 rtl/test_csr_rsp_fifo.sv | 60 ++++++
 rtl/test_csr_mmio_mgr.sv | 152 +++++++++++++++
 tb/tb_test_csr_mmio_mgr.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/test_csr_mgr_pkg.sv
// Shared constants and payload types for the test CSR MMIO manager.
package test_csr_mgr_pkg;

    localparam int unsigned NUM_TEST_CSRS = 8;
    localparam int unsigned CSR_IDX_W     = $clog2(NUM_TEST_CSRS);

    // Byte offsets in the AFU MMIO space
    localparam int unsigned DFH_OFF       = 'h00;
    localparam int unsigned AFU_ID_L_OFF  = 'h08;
    localparam int unsigned AFU_ID_H_OFF  = 'h10;
    localparam int unsigned TEST_CSR_BASE = 'h40;
    localparam int unsigned STATS_BASE    = 'h80;

    // AFU type, end-of-list
    localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

    typedef logic [8:0] t_mmio_tid;

    typedef struct packed {
        t_mmio_tid   tid;
        logic [63:0] data;
    } t_mmio_rsp;

    typedef struct packed {
        logic        en;
        logic [63:0] data;
    } t_cpu_wr_csr;

endpackage

// File: rtl/test_csrs.sv
// CSR exchange between the MMIO manager and the test module.
interface test_csrs;
    import test_csr_mgr_pkg::*;

    logic [127:0] afu_id;
    logic [63:0]  cpu_rd_csrs [NUM_TEST_CSRS];
    t_cpu_wr_csr  cpu_wr_csrs [NUM_TEST_CSRS];

    modport csr  (input afu_id, input cpu_rd_csrs, output cpu_wr_csrs);
    modport test (output afu_id, output cpu_rd_csrs, input cpu_wr_csrs);
endinterface

// File: rtl/test_csr_rsp_fifo.sv
// Show-ahead read-response FIFO; pushes into a full FIFO without a pop are dropped
// and latch a sticky overflow flag.
module test_csr_rsp_fifo
    import test_csr_mgr_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push_i,
    input  t_mmio_rsp push_data_i,
    input  logic      pop_i,
    output t_mmio_rsp head_o,
    output logic      empty_o,
    output logic      overflow_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned PW = AW + 1;

    t_mmio_rsp       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic            ovf_q, ovf_d;
    logic            full, empty, do_push, do_pop;

    // Flags, pointer advance and overflow detection
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
        do_pop   = pop_i && !empty;
        do_push  = push_i && (!full || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        if (push_i && full && !do_pop) ovf_d = 1'b1;
    end

    // Storage and pointer registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

    assign head_o     = mem_q[rd_ptr_q[AW-1:0]];
    assign empty_o    = empty;
    assign overflow_o = ovf_q;

endmodule

// File: rtl/test_csr_mmio_mgr.sv
// MMIO CSR manager: decodes host reads/writes, returns buffered read responses and
// issues one-cycle write strobes to the test module.
// Optional build macro: TEST_CSR_MMIO_STATS_EN adds MMIO read/write counters at 0x80/0x88.
module test_csr_mmio_mgr
    import test_csr_mgr_pkg::*;
#(
    parameter int unsigned RSP_FIFO_DEPTH = 4,
    parameter int unsigned MMIO_ADDR_BITS = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      mmio_wr_valid,
    input  logic [MMIO_ADDR_BITS-1:0] mmio_wr_addr,
    input  logic [63:0]               mmio_wr_data,
    input  logic                      mmio_rd_valid,
    input  logic [MMIO_ADDR_BITS-1:0] mmio_rd_addr,
    input  logic [8:0]                mmio_rd_tid,
    input  logic                      mmio_rsp_ready,
    output logic                      mmio_rsp_valid,
    output logic [8:0]                mmio_rsp_tid,
    output logic [63:0]               mmio_rsp_data,
    output logic                      rsp_overflow,
    test_csrs.csr                     csrs
);

    localparam int unsigned AW = MMIO_ADDR_BITS;
    localparam logic [AW-1:0] CSR_BASE_W = AW'(TEST_CSR_BASE / 4);
    localparam logic [AW-1:0] CSR_SPAN_W = AW'(2 * NUM_TEST_CSRS);

    // Stage 1 read request registers
    logic            rd_valid_q;
    logic [AW-1:0]   rd_addr_q;
    t_mmio_tid       rd_tid_q;

    // Write strobe / held data registers
    t_cpu_wr_csr     wr_csrs_q [NUM_TEST_CSRS];
    t_cpu_wr_csr     wr_csrs_d [NUM_TEST_CSRS];

    logic [AW-1:0]        wr_off, rd_off;
    logic [CSR_IDX_W-1:0] wr_idx, rd_idx;
    logic                 wr_hit;
    logic [63:0]          rd_data;
    t_mmio_rsp            rsp_push, rsp_head;
    logic                 fifo_empty;

`ifdef TEST_CSR_MMIO_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d;
    logic [31:0] wr_cnt_q, wr_cnt_d;
    logic        stats_clr;

    // Saturating request counters; a write to STATS_BASE clears both
    always_comb begin
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        stats_clr = mmio_wr_valid && (mmio_wr_addr == AW'(STATS_BASE / 4));
        if (stats_clr) begin
            rd_cnt_d = '0;
            wr_cnt_d = '0;
        end else begin
            if (mmio_rd_valid && (rd_cnt_q != 32'hFFFF_FFFF)) rd_cnt_d = rd_cnt_q + 32'd1;
            if (mmio_wr_valid && (wr_cnt_q != 32'hFFFF_FFFF)) wr_cnt_d = wr_cnt_q + 32'd1;
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end
`endif

    // Write decode: even word inside the test CSR window
    always_comb begin
        wr_off = mmio_wr_addr - CSR_BASE_W;
        wr_idx = wr_off[CSR_IDX_W:1];
        wr_hit = mmio_wr_valid && !mmio_wr_addr[0] && (wr_off < CSR_SPAN_W);
        for (int i = 0; i < int'(NUM_TEST_CSRS); i++) begin
            wr_csrs_d[i].en   = wr_hit && (wr_idx == CSR_IDX_W'(i));
            wr_csrs_d[i].data = wr_csrs_d[i].en ? mmio_wr_data : wr_csrs_q[i].data;
        end
    end

    // Write strobe registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_TEST_CSRS); i++) wr_csrs_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(NUM_TEST_CSRS); i++) wr_csrs_q[i] <= wr_csrs_d[i];
        end
    end

    for (genvar g = 0; g < int'(NUM_TEST_CSRS); g++) begin : g_wr_out
        assign csrs.cpu_wr_csrs[g] = wr_csrs_q[g];
    end

    // Read stage 1: capture request
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            rd_tid_q   <= '0;
        end else begin
            rd_valid_q <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                rd_addr_q <= mmio_rd_addr;
                rd_tid_q  <= mmio_rd_tid;
            end
        end
    end

    // Read stage 2: data mux; odd or unmapped addresses return zero
    always_comb begin
        rd_data = '0;
        rd_off  = rd_addr_q - CSR_BASE_W;
        rd_idx  = rd_off[CSR_IDX_W:1];
        if (!rd_addr_q[0]) begin
            if (rd_addr_q == AW'(DFH_OFF / 4))           rd_data = DFH_VALUE;
            else if (rd_addr_q == AW'(AFU_ID_L_OFF / 4)) rd_data = csrs.afu_id[63:0];
            else if (rd_addr_q == AW'(AFU_ID_H_OFF / 4)) rd_data = csrs.afu_id[127:64];
            else if (rd_off < CSR_SPAN_W)                rd_data = csrs.cpu_rd_csrs[rd_idx];
`ifdef TEST_CSR_MMIO_STATS_EN
            else if (rd_addr_q == AW'(STATS_BASE / 4))       rd_data = {32'b0, rd_cnt_q};
            else if (rd_addr_q == AW'((STATS_BASE + 8) / 4)) rd_data = {32'b0, wr_cnt_q};
`endif
        end
        rsp_push.tid  = rd_tid_q;
        rsp_push.data = rd_data;
    end

    test_csr_rsp_fifo #(
        .DEPTH       (RSP_FIFO_DEPTH)
    ) u_rsp_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (rd_valid_q),
        .push_data_i (rsp_push),
        .pop_i       (mmio_rsp_ready),
        .head_o      (rsp_head),
        .empty_o     (fifo_empty),
        .overflow_o  (rsp_overflow)
    );

    assign mmio_rsp_valid = !fifo_empty;
    assign mmio_rsp_tid   = rsp_head.tid;
    assign mmio_rsp_data  = rsp_head.data;

endmodule

// File: tb/tb_test_csr_mmio_mgr.sv
// Scoreboard bench for test_csr_mmio_mgr: stimulus pushes expected responses,
// a negedge monitor pops and compares them.
module tb_test_csr_mmio_mgr;
    import test_csr_mgr_pkg::*;

    localparam int unsigned AW = 16;

    typedef struct {
        logic [8:0]  tid;
        logic [63:0] data;
        int          cyc;
        bit          chk_cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          mmio_wr_valid = 1'b0;
    logic [AW-1:0] mmio_wr_addr = '0;
    logic [63:0]   mmio_wr_data = '0;
    logic          mmio_rd_valid = 1'b0;
    logic [AW-1:0] mmio_rd_addr = '0;
    logic [8:0]    mmio_rd_tid = '0;
    logic          mmio_rsp_ready = 1'b1;
    logic          mmio_rsp_valid;
    logic [8:0]    mmio_rsp_tid;
    logic [63:0]   mmio_rsp_data;
    logic          rsp_overflow;

    test_csrs csrs_if ();

    test_csr_mmio_mgr #(
        .RSP_FIFO_DEPTH (4),
        .MMIO_ADDR_BITS (AW)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .mmio_wr_valid  (mmio_wr_valid),
        .mmio_wr_addr   (mmio_wr_addr),
        .mmio_wr_data   (mmio_wr_data),
        .mmio_rd_valid  (mmio_rd_valid),
        .mmio_rd_addr   (mmio_rd_addr),
        .mmio_rd_tid    (mmio_rd_tid),
        .mmio_rsp_ready (mmio_rsp_ready),
        .mmio_rsp_valid (mmio_rsp_valid),
        .mmio_rsp_tid   (mmio_rsp_tid),
        .mmio_rsp_data  (mmio_rsp_data),
        .rsp_overflow   (rsp_overflow),
        .csrs           (csrs_if)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    exp_t exp_q[$];

    localparam logic [127:0] AFU_ID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    logic [63:0] rd_vals [NUM_TEST_CSRS];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        n_chk++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, want, cyc);
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (mmio_rsp_valid && mmio_rsp_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_rsp", {55'b0, mmio_rsp_tid}, 64'h1FF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_tid", {55'b0, mmio_rsp_tid}, {55'b0, e.tid});
                chk("rsp_data", mmio_rsp_data, e.data);
                if (e.chk_cyc) chk("rsp_latency_cyc", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input int byte_addr, input logic [8:0] tid, input logic [63:0] want,
                      input bit expect_rsp, input bit chk_lat);
        exp_t e;
        mmio_rd_valid = 1'b1;
        mmio_rd_addr  = AW'(byte_addr >> 2);
        mmio_rd_tid   = tid;
        if (expect_rsp) begin
            e.tid = tid; e.data = want; e.cyc = cyc + 2; e.chk_cyc = chk_lat;
            exp_q.push_back(e);
        end
        tick();
        mmio_rd_valid = 1'b0;
    endtask

    task automatic wr(input int byte_addr, input logic [63:0] data);
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = AW'(byte_addr >> 2);
        mmio_wr_data  = data;
        tick();
        mmio_wr_valid = 1'b0;
    endtask

    function automatic logic [63:0] en_vec();
        logic [63:0] v;
        v = '0;
        for (int i = 0; i < int'(NUM_TEST_CSRS); i++) v[i] = csrs_if.cpu_wr_csrs[i].en;
        return v;
    endfunction

    task automatic wait_drain();
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) tick();
        chk("drain_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rsp_valid"}, {63'b0, mmio_rsp_valid}, 64'd0);
        chk({tag, "_rsp_tid"}, {55'b0, mmio_rsp_tid}, 64'd0);
        chk({tag, "_rsp_data"}, mmio_rsp_data, 64'd0);
        chk({tag, "_overflow"}, {63'b0, rsp_overflow}, 64'd0);
        chk({tag, "_wr_en"}, en_vec(), 64'd0);
        for (int i = 0; i < int'(NUM_TEST_CSRS); i++)
            chk($sformatf("%s_wr_data%0d", tag, i), csrs_if.cpu_wr_csrs[i].data, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got cyc %0d expected < 10000", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        csrs_if.afu_id = AFU_ID;
        for (int i = 0; i < int'(NUM_TEST_CSRS); i++) begin
            rd_vals[i] = 64'h0000_C5C5_0000_0000 + 64'(i);
            csrs_if.cpu_rd_csrs[i] = rd_vals[i];
        end

        // Reset state
        repeat (3) tick();
        chk_reset_vals("reset");
        reset = 1'b0;
        tick();

        // Fixed-map reads, back to back, latency 2
        rd('h00, 9'h05, DFH_VALUE, 1, 1);
        rd('h08, 9'h06, AFU_ID[63:0], 1, 1);
        rd('h10, 9'h07, AFU_ID[127:64], 1, 1);
        rd('h18, 9'h08, 64'd0, 1, 1);
        rd('h20, 9'h09, 64'd0, 1, 1);
        rd('h04, 9'h0A, 64'd0, 1, 1);
        rd('h40, 9'h0B, rd_vals[0], 1, 1);
        rd('h48, 9'h0C, rd_vals[1], 1, 1);
        rd('h200, 9'h0D, 64'd0, 1, 1);
        wait_drain();

        // Write strobe to CSR 2
        wr('h50, 64'hDEAD_BEEF_0000_0003);
        chk("wr2_en_n1", en_vec(), 64'h4);
        chk("wr2_data_n1", csrs_if.cpu_wr_csrs[2].data, 64'hDEAD_BEEF_0000_0003);
        tick();
        chk("wr2_en_n2", en_vec(), 64'h0);
        chk("wr2_data_hold", csrs_if.cpu_wr_csrs[2].data, 64'hDEAD_BEEF_0000_0003);

        // Odd address and non-CSR writes are dropped
        wr('h5C, 64'h1111);
        chk("odd_wr_en", en_vec(), 64'h0);
        tick();
        chk("odd_wr_data3", csrs_if.cpu_wr_csrs[3].data, 64'd0);
        wr('h08, 64'h2222);
        chk("afuid_wr_en", en_vec(), 64'h0);

        // Simultaneous read and write of CSR 7
        csrs_if.cpu_rd_csrs[7] = 64'hA5;
        mmio_wr_valid = 1'b1;
        mmio_wr_addr  = AW'('h78 >> 2);
        mmio_wr_data  = 64'h1234;
        rd('h78, 9'h42, 64'hA5, 1, 1);
        mmio_wr_valid = 1'b0;
        chk("rw7_en", en_vec(), 64'h80);
        chk("rw7_wr_data", csrs_if.cpu_wr_csrs[7].data, 64'h1234);
        wait_drain();

        // Overflow: ready low, five reads into a depth-4 FIFO
        mmio_rsp_ready = 1'b0;
        for (int k = 1; k <= 5; k++)
            rd('h40 + 8 * (k - 1), 9'(k), rd_vals[k-1], k <= 4, 0);
        chk("ovf_before", {63'b0, rsp_overflow}, 64'd0);
        chk("full_valid", {63'b0, mmio_rsp_valid}, 64'd1);
        tick();
        chk("ovf_after", {63'b0, rsp_overflow}, 64'd1);
        chk("full_head_tid", {55'b0, mmio_rsp_tid}, 64'd1);
        mmio_rsp_ready = 1'b1;
        repeat (4) tick();
        chk("drained_in_4", {63'b0, mmio_rsp_valid}, 64'd0);
        chk("ovf_sticky", {63'b0, rsp_overflow}, 64'd1);
        wait_drain();

        // Reset while reads are in flight
        rd('h00, 9'h1A, 64'd0, 0, 0);
        reset = 1'b1;
        rd('h08, 9'h1B, 64'd0, 0, 0);
        rd('h10, 9'h1C, 64'd0, 0, 0);
        tick();
        chk_reset_vals("midrst");
        reset = 1'b0;
        repeat (5) tick();
        chk("post_rst_valid", {63'b0, mmio_rsp_valid}, 64'd0);
        chk("post_rst_ovf", {63'b0, rsp_overflow}, 64'd0);

`ifdef TEST_CSR_MMIO_STATS_EN
        // Request counters
        wr('h40, 64'h1);
        wr('h200, 64'h2);
        wr('h48, 64'h3);
        tick();
        rd('h88, 9'h30, 64'd3, 1, 1);
        rd('h80, 9'h31, 64'd2, 1, 1);
        wait_drain();
        wr('h80, 64'h0);
        rd('h80, 9'h32, 64'd1, 1, 1);
        wait_drain();
`else
        // Stats window absent
        rd('h80, 9'h30, 64'd0, 1, 1);
        rd('h88, 9'h31, 64'd0, 1, 1);
        wr('h80, 64'hFFFF);
        chk("stats_wr_en", en_vec(), 64'h0);
        wait_drain();
`endif

        repeat (3) tick();
        chk("final_queue", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
